// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lights codes, phase/state enums and phase-order helper
package traffic_pkg;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;

  typedef enum logic [1:0] {
    PH_RED     = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_UNKNOWN = 2'd3
  } phase_t;

  typedef enum logic {
    ST_UNLOCK = 1'b0,
    ST_TRACK  = 1'b1
  } mon_state_t;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - lights bus plus monitor status outputs
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       lights;
  logic             clr_err;
  logic [1:0]       phase;
  logic             locked;
  logic             err_encoding;
  logic             err_sequence;
  logic             err_dwell;
  logic             err_sticky;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output lights, clr_err,
    input  phase, locked, err_encoding, err_sequence, err_dwell, err_sticky, cycle_count
  );

  modport slave (
    input  lights, clr_err,
    output phase, locked, err_encoding, err_sequence, err_dwell, err_sticky, cycle_count
  );
endinterface

// File: rtl/traffic_light_decoder.sv
// rtl/traffic_light_decoder.sv - combinational lights code to {valid, phase}
module traffic_light_decoder
  import traffic_pkg::*;
(
  input  logic [2:0] lights,
  output logic       valid,
  output phase_t     phase
);

  always_comb begin
    valid = 1'b1;
    phase = PH_UNKNOWN;
    case (lights)
      LT_RED:    phase = PH_RED;
      LT_GREEN:  phase = PH_GREEN;
      LT_YELLOW: phase = PH_YELLOW;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - checks encoding, phase order and dwell of the lights bus
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 1,
  parameter int CNT_W     = 8
) (
  input logic                    clk,
  input logic                    reset,
  traffic_light_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mon_state_t       state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enc_q, enc_d;
  logic             seq_q, seq_d;
  logic             dwl_q, dwl_d;
  logic             sticky_q, sticky_d;
  logic             code_valid;
  phase_t           code_phase;

  traffic_light_decoder u_decoder (
    .lights (bus.lights),
    .valid  (code_valid),
    .phase  (code_phase)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_UNLOCK;
      phase_q  <= PH_UNKNOWN;
      dwell_q  <= '0;
      count_q  <= '0;
      enc_q    <= 1'b0;
      seq_q    <= 1'b0;
      dwl_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dwell_q  <= dwell_d;
      count_q  <= count_d;
      enc_q    <= enc_d;
      seq_q    <= seq_d;
      dwl_q    <= dwl_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    count_d = count_q;
    enc_d   = 1'b0;
    seq_d   = 1'b0;
    dwl_d   = 1'b0;
    case (state_q)
      ST_UNLOCK: begin
        if (!code_valid) begin
          enc_d = 1'b1;
        end else begin
          state_d = ST_TRACK;
          phase_d = code_phase;
          dwell_d = CNT_ONE;
        end
      end
      ST_TRACK: begin
        if (!code_valid) begin
          enc_d   = 1'b1;
          state_d = ST_UNLOCK;
          phase_d = PH_UNKNOWN;
          dwell_d = '0;
        end else if (code_phase == phase_q) begin
          if (dwell_q != CNT_MAX) dwell_d = dwell_q + CNT_ONE;
          // Fires only on the sample that first crosses the limit
          if (MAX_DWELL != 0 && 32'(dwell_q) == MAX_DWELL) dwl_d = 1'b1;
        end else if (code_phase == next_phase(phase_q)) begin
          if (32'(dwell_q) < MIN_DWELL) dwl_d = 1'b1;
          phase_d = code_phase;
          dwell_d = CNT_ONE;
          if (code_phase == PH_RED && count_q != CNT_MAX) count_d = count_q + CNT_ONE;
        end else begin
          seq_d   = 1'b1;
          phase_d = code_phase;
          dwell_d = CNT_ONE;
        end
      end
      default: state_d = ST_UNLOCK;
    endcase
    sticky_d = enc_d | seq_d | dwl_d | (sticky_q & ~bus.clr_err);
  end

  assign bus.phase        = phase_q;
  assign bus.locked       = (state_q == ST_TRACK);
  assign bus.err_encoding = enc_q;
  assign bus.err_sequence = seq_q;
  assign bus.err_dwell    = dwl_q;
  assign bus.err_sticky   = sticky_q;
  assign bus.cycle_count  = count_q;

endmodule
